truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Parametrised, self-checking exhaustive stimulus engine for combinational Boolean blocks.
- Drives all 2^N_IN input combinations onto a DUT in ascending order and waits a programmable settle time per vector.
- Samples the DUT output and compares it against a golden truth table parameter.
- Reports pass/fail, mismatch count and first failing index; supports single-shot, continuous-loop and abort.

Parameters:
- N_IN, 3, number of DUT inputs; stim index packs the inputs MSB-first (e.g. {x,y,z}); range 1..16.
- TRUTH_TABLE, 8'b1110_1000, expected output; bit k = expected f for stim==k; width 2^N_IN (default is 3-input majority).
- SETTLE, 1, extra wait cycles per vector before sampling; 0 allowed; range 0..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep; level sampled in IDLE only
- loop  in  1  1 = restart a new sweep immediately after each completed sweep
- abort  in  1  terminate current sweep, return to IDLE
- f_in  in  1  DUT output under test
- stim  out  N_IN  vector applied to DUT inputs
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse on sweep completion
- pass  out  1  last completed sweep had zero mismatches
- err_count  out  N_IN+1  mismatch count of last completed sweep
- first_fail_valid  out  1  last completed sweep had at least one mismatch
- first_fail_idx  out  N_IN  lowest failing stim index of last completed sweep

Behaviour:
- Reset (async assert, sync release) sets every output to 0, the FSM to IDLE, and all internal counters to 0.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge:
  - stim<=0, wait_cnt<=SETTLE, live counters cleared, busy<=1, state RUN.
  - start=0: hold; stim holds its last value.
- RUN, wait_cnt!=0: wait_cnt decrements; stim held.
- RUN, wait_cnt==0 is the sample edge:
  - mismatch = f_in != TRUTH_TABLE[stim].
  - On mismatch, live_err increments.
  - If this is the first mismatch of the sweep, live_idx<=stim and live_fv<=1.
  - If stim != all-ones: stim<=stim+1, wait_cnt<=SETTLE.
- Final vector sample edge (stim all-ones):
  - Results latch: err_count, pass, first_fail_valid and first_fail_idx, including that edge's compare.
  - done<=1 for one cycle.
  - loop=1: stim<=0, live counters cleared, wait_cnt<=SETTLE, remain RUN, busy stays 1.
  - loop=0: busy<=0, state IDLE, stim holds all-ones.
- Latency: each vector occupies SETTLE+1 cycles. A sweep occupies 2^N_IN*(SETTLE+1) cycles from the start-accept edge. done is high in the cycle after the final sample edge.
- Result outputs change only on done. They hold previous-sweep values during a running sweep, after abort, and while idle.
- err_count width N_IN+1 holds the maximum 2^N_IN (all mismatch) without wrap; no saturation logic is needed.
- start while busy is ignored; no queueing.
- abort has priority over sampling and completion on the same edge. Effects next edge: busy<=0, state IDLE, no done, results unchanged, stim holds.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins, no sweep starts.
- loop deasserted mid-sweep: the current sweep finishes, then the block stops. loop is sampled only at the final sample edge.
- Reset mid-sweep: immediate return to all-zero outputs; no done is generated.

Test Plan:
1. Defaults; f_in driven by a correct majority model of stim; start pulse:
   - stim steps 0..7, changing every 2 cycles; busy high 16 cycles.
   - Single done pulse; pass=1, err_count=0, first_fail_valid=0.
2. Model inverted at indices 5 and 6 → pass=0, err_count=2, first_fail_valid=1, first_fail_idx=5.
3. f_in tied 0 → err_count=4, first_fail_idx=3. Then f_in tied to ~expected (all mismatch) → err_count=8 (no wrap).
4. loop=1, SETTLE=0, correct model:
   - done pulses every 8 cycles and busy never drops.
   - Deassert loop mid-sweep → exactly one more done, then busy=0.
5. Sweep with faults, then start a second sweep and abort at stim=4:
   - busy falls next edge with no done.
   - pass, err_count and first_fail_idx keep the first sweep's values.
   - A start pulse during busy is ignored (stim is not reset to 0).
6. Assert rst_n low at stim=3 mid-sweep:
   - All outputs 0 asynchronously, no done.
   - After release, a fresh start completes normally with correct results.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input combination of a combinational
// block, samples its output after a settle delay and scores it against a golden table.
module truth_table_sweeper #(
    parameter int                       N_IN        = 3,
    parameter logic [(1<<N_IN)-1:0]     TRUTH_TABLE = 8'b1110_1000,
    parameter int                       SETTLE      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            loop,
    input  logic            abort,
    input  logic            f_in,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);
    localparam logic [N_IN-1:0] STIM_LAST  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [7:0]        wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic              ffv_q, ffv_d;
    logic [N_IN-1:0]   ffi_q, ffi_d;
    logic [N_IN:0]     live_err_q, live_err_d;
    logic              live_fv_q, live_fv_d;
    logic [N_IN-1:0]   live_idx_q, live_idx_d;

    logic              mismatch_s;
    logic [N_IN:0]     sweep_err_s;
    logic              sweep_fv_s;
    logic [N_IN-1:0]   sweep_idx_s;

    // Score the current vector and fold it into the running sweep totals.
    always_comb begin
        mismatch_s  = (f_in != TRUTH_TABLE[stim_q]);
        sweep_err_s = live_err_q + {{N_IN{1'b0}}, mismatch_s};
        sweep_fv_s  = live_fv_q | mismatch_s;
        if (live_fv_q) begin
            sweep_idx_s = live_idx_q;
        end else if (mismatch_s) begin
            sweep_idx_s = stim_q;
        end else begin
            sweep_idx_s = live_idx_q;
        end
    end

    // Next-state logic; abort outranks sampling and completion.
    always_comb begin
        state_d    = state_q;
        stim_d     = stim_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        ffi_d      = ffi_q;
        live_err_d = live_err_q;
        live_fv_d  = live_fv_q;
        live_idx_d = live_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_RUN;
                    stim_d     = {N_IN{1'b0}};
                    wait_d     = SETTLE_CNT;
                    busy_d     = 1'b1;
                    live_err_d = {(N_IN+1){1'b0}};
                    live_fv_d  = 1'b0;
                    live_idx_d = {N_IN{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else if (stim_q != STIM_LAST) begin
                    stim_d     = stim_q + STIM_ONE;
                    wait_d     = SETTLE_CNT;
                    live_err_d = sweep_err_s;
                    live_fv_d  = sweep_fv_s;
                    live_idx_d = sweep_idx_s;
                end else begin
                    // Final vector: publish results including this edge's compare.
                    done_d = 1'b1;
                    err_d  = sweep_err_s;
                    pass_d = ~sweep_fv_s;
                    ffv_d  = sweep_fv_s;
                    ffi_d  = sweep_idx_s;
                    if (loop) begin
                        stim_d     = {N_IN{1'b0}};
                        wait_d     = SETTLE_CNT;
                        live_err_d = {(N_IN+1){1'b0}};
                        live_fv_d  = 1'b0;
                        live_idx_d = {N_IN{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stim_q     <= {N_IN{1'b0}};
            wait_q     <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= {(N_IN+1){1'b0}};
            ffv_q      <= 1'b0;
            ffi_q      <= {N_IN{1'b0}};
            live_err_q <= {(N_IN+1){1'b0}};
            live_fv_q  <= 1'b0;
            live_idx_q <= {N_IN{1'b0}};
        end else begin
            state_q    <= state_d;
            stim_q     <= stim_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ffv_q      <= ffv_d;
            ffi_q      <= ffi_d;
            live_err_q <= live_err_d;
            live_fv_q  <= live_fv_d;
            live_idx_q <= live_idx_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a SETTLE=1 instance for single sweeps, faults, abort
// and reset, plus a SETTLE=0 instance for continuous looping.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, loop1, abort1, f1;
    logic [2:0] stim1, ffi1;
    logic       busy1, done1, pass1, ffv1;
    logic [3:0] err1;
    logic       start0, loop0, abort0, f0;
    logic [2:0] stim0, ffi0;
    logic       busy0, done0, pass0, ffv0;
    logic [3:0] err0;

    logic [7:0] mask1;
    logic       tied0;
    int checks = 0;
    int errors = 0;

    // Golden reference: 3-input majority computed arithmetically.
    function automatic logic maj(input logic [2:0] k);
        return (int'(k[2]) + int'(k[1]) + int'(k[0])) >= 2;
    endfunction

    assign f1 = tied0 ? 1'b0 : (maj(stim1) ^ mask1[stim1]);
    assign f0 = maj(stim0);

    truth_table_sweeper #(.N_IN(3), .TRUTH_TABLE(8'b1110_1000), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .loop(loop1), .abort(abort1), .f_in(f1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_idx(ffi1));

    truth_table_sweeper #(.N_IN(3), .TRUTH_TABLE(8'b1110_1000), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .loop(loop0), .abort(abort0), .f_in(f0),
        .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_valid(ffv0), .first_fail_idx(ffi0));

    // Expected sweep result from the fault description.
    task automatic model(input logic [7:0] mask, input logic tz, output int e, output int fi);
        logic exp_v, got_v;
        e  = 0;
        fi = -1;
        for (int k = 0; k < 8; k++) begin
            exp_v = maj(3'(k));
            got_v = tz ? 1'b0 : (exp_v ^ mask[k]);
            if (got_v != exp_v) begin
                e++;
                if (fi < 0) fi = k;
            end
        end
    endtask

    // Pulse start on instance 1 and observe 20 cycles (SETTLE=1 sweep).
    task automatic run_sweep1(output int busy_n, output int done_n, output int done_at,
                              output bit seq_ok);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1; seq_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy1) begin
                busy_n++;
                if (stim1 !== 3'((k - 1) / 2)) seq_ok = 1'b0;
            end
            if (done1) begin
                done_n++;
                done_at = k;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({stim1, busy1, done1, pass1, err1, ffv1, ffi1} !== 15'd0) begin
            errors++; $display("FAIL reset_inst1: got %h expected 0", {stim1, busy1, done1, pass1, err1, ffv1, ffi1});
        end
        checks++;
        if ({stim0, busy0, done0, pass0, err0, ffv0, ffi0} !== 15'd0) begin
            errors++; $display("FAIL reset_inst0: got %h expected 0", {stim0, busy0, done0, pass0, err0, ffv0, ffi0});
        end
    endtask

    task automatic test_basic;
        int bn, dn, da, e, fi;
        bit ok;
        mask1 = 8'h00; tied0 = 1'b0;
        run_sweep1(bn, dn, da, ok);
        model(mask1, tied0, e, fi);
        checks++; if (bn !== 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", bn); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
        checks++; if (da !== 17) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 17", da); end
        checks++; if (!ok) begin errors++; $display("FAIL basic_stim_seq: got 0 expected 1"); end
        checks++; if (stim1 !== 3'd7) begin errors++; $display("FAIL basic_stim_hold: got %0d expected 7", stim1); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL basic_pass: got %0d expected 1", pass1); end
        checks++; if (err1 !== 4'(e)) begin errors++; $display("FAIL basic_err: got %0d expected %0d", err1, e); end
        checks++; if (ffv1 !== 1'b0) begin errors++; $display("FAIL basic_ffv: got %0d expected 0", ffv1); end
    endtask

    task automatic test_faults;
        logic [7:0] masks [0:8];
        logic       tz    [0:8];
        int bn, dn, da, e, fi;
        bit ok;
        masks[0] = 8'h60; tz[0] = 1'b0;
        masks[1] = 8'h00; tz[1] = 1'b1;
        masks[2] = 8'hFF; tz[2] = 1'b0;
        for (int i = 3; i < 9; i++) begin
            masks[i] = 8'($urandom_range(0, 255));
            tz[i]    = 1'b0;
        end
        for (int i = 0; i < 9; i++) begin
            mask1 = masks[i]; tied0 = tz[i];
            run_sweep1(bn, dn, da, ok);
            model(masks[i], tz[i], e, fi);
            checks++; if (dn !== 1 || da !== 17) begin errors++; $display("FAIL fault%0d_done: got %0d@%0d expected 1@17", i, dn, da); end
            checks++; if (err1 !== 4'(e)) begin errors++; $display("FAIL fault%0d_err: got %0d expected %0d", i, err1, e); end
            checks++; if (pass1 !== (e == 0)) begin errors++; $display("FAIL fault%0d_pass: got %0d expected %0d", i, pass1, e == 0); end
            checks++; if (ffv1 !== (e != 0)) begin errors++; $display("FAIL fault%0d_ffv: got %0d expected %0d", i, ffv1, e != 0); end
            if (e != 0) begin
                checks++; if (ffi1 !== 3'(fi)) begin errors++; $display("FAIL fault%0d_ffi: got %0d expected %0d", i, ffi1, fi); end
            end
        end
        tied0 = 1'b0;
    endtask

    task automatic test_loop;
        int dn;
        @(negedge clk); loop0 = 1'b1; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL loop_busy_k%0d: got %0d expected 1", k, busy0); end
            checks++; if (done0 !== (k == 9 || k == 17)) begin errors++; $display("FAIL loop_done_k%0d: got %0d expected %0d", k, done0, k == 9 || k == 17); end
            checks++; if (stim0 !== 3'((k - 1) % 8)) begin errors++; $display("FAIL loop_stim_k%0d: got %0d expected %0d", k, stim0, (k - 1) % 8); end
        end
        loop0 = 1'b0;
        dn = 0;
        for (int k = 21; k <= 40; k++) begin
            @(negedge clk);
            if (done0) dn++;
            if (k == 25) begin
                checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL loop_stop_k25: got done=%0d busy=%0d expected done=1 busy=0", done0, busy0); end
            end
        end
        checks++; if (dn !== 1) begin errors++; $display("FAIL loop_tail_done: got %0d expected 1", dn); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL loop_end_busy: got %0d expected 0", busy0); end
        checks++; if (pass0 !== 1'b1 || err0 !== 4'd0) begin errors++; $display("FAIL loop_result: got pass=%0d err=%0d expected pass=1 err=0", pass0, err0); end
    endtask

    task automatic test_abort;
        int bn, dn, da, e, fi, cnt;
        bit ok, hit;
        mask1 = 8'h60;
        run_sweep1(bn, dn, da, ok);
        model(mask1, 1'b0, e, fi);
        checks++; if (err1 !== 4'(e) || ffi1 !== 3'(fi)) begin errors++; $display("FAIL abort_pre: got err=%0d idx=%0d expected err=%0d idx=%0d", err1, ffi1, e, fi); end
        mask1 = 8'h00;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (stim1 == 3'd2) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_wait2: got timeout expected stim=2"); end
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        checks++; if (stim1 !== 3'd2 || busy1 !== 1'b1) begin errors++; $display("FAIL busy_start_ignored: got stim=%0d busy=%0d expected stim=2 busy=1", stim1, busy1); end
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (stim1 == 3'd4) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_wait4: got timeout expected stim=4"); end
        abort1 = 1'b1;
        @(negedge clk); abort1 = 1'b0;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL abort_stop: got busy=%0d done=%0d expected 0 0", busy1, done1); end
        checks++; if (stim1 !== 3'd4) begin errors++; $display("FAIL abort_stim_hold: got %0d expected 4", stim1); end
        checks++; if (pass1 !== 1'b0 || err1 !== 4'(e) || ffv1 !== 1'b1 || ffi1 !== 3'(fi)) begin
            errors++; $display("FAIL abort_results: got pass=%0d err=%0d ffv=%0d idx=%0d expected 0 %0d 1 %0d", pass1, err1, ffv1, ffi1, e, fi);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) cnt++;
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", cnt); end
        start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
        checks++; if (busy1 !== 1'b0 || stim1 !== 3'd4) begin errors++; $display("FAIL abort_beats_start: got busy=%0d stim=%0d expected 0 4", busy1, stim1); end
    endtask

    task automatic test_reset_mid;
        int bn, dn, da, e, fi;
        bit ok, hit;
        mask1 = 8'($urandom_range(1, 255));
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (stim1 == 3'd3) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL reset_wait3: got timeout expected stim=3"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stim1, busy1, done1, pass1, err1, ffv1, ffi1} !== 15'd0) begin
            errors++; $display("FAIL reset_mid_async: got %h expected 0", {stim1, busy1, done1, pass1, err1, ffv1, ffi1});
        end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_mid_done: got %0d expected 0", done1); end
        rst_n = 1'b1;
        run_sweep1(bn, dn, da, ok);
        model(mask1, 1'b0, e, fi);
        checks++; if (dn !== 1 || !ok) begin errors++; $display("FAIL post_reset_sweep: got done=%0d seq=%0d expected 1 1", dn, ok); end
        checks++; if (err1 !== 4'(e) || ffv1 !== 1'b1 || ffi1 !== 3'(fi)) begin
            errors++; $display("FAIL post_reset_result: got err=%0d ffv=%0d idx=%0d expected %0d 1 %0d", err1, ffv1, ffi1, e, fi);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; loop1 = 1'b0; abort1 = 1'b0;
        start0 = 1'b0; loop0 = 1'b0; abort0 = 1'b0;
        mask1 = 8'h00; tied0 = 1'b0;
        @(negedge clk); @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_basic;
        test_faults;
        test_loop;
        test_abort;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
